// File: rtl/bf_pdep_pipe_if.sv
// Bundle of the stream-in, stream-out and config-write signals of bf_pdep_pipe.
// slave is the pipeline's view; master is the producer/consumer view.
interface bf_pdep_pipe_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 2,
    parameter int ADDR_WIDTH = 2
);
    localparam int N    = DATA_WIDTH / LANES;
    localparam int HALF = N / 2;

    // Both streams use valid/ready: a beat moves on a clock edge where valid and
    // ready are both 1; valid and its payload stay put until that happens.
    logic                  s_valid;
    logic                  s_ready;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  cfg_we;
    logic [ADDR_WIDTH-1:0] cfg_addr;
    logic [7:0]            cfg_stage;
    logic [HALF-1:0]       cfg_wdata;
    logic                  cfg_err;

    modport slave (
        input  s_valid, s_addr, s_data, m_ready, cfg_we, cfg_addr, cfg_stage, cfg_wdata,
        output s_ready, m_valid, m_data, cfg_err
    );

    modport master (
        output s_valid, s_addr, s_data, m_ready, cfg_we, cfg_addr, cfg_stage, cfg_wdata,
        input  s_ready, m_valid, m_data, cfg_err
    );
endinterface

// File: rtl/bf_pdep_pipe.sv
// Bit-plane butterfly network with per-beat selectable control words; stages
// flagged in PIPED_MASK are registered, the rest are combinational.
module bf_pdep_pipe #(
    parameter int                   DATA_WIDTH = 16,
    parameter int                   LANES      = 2,
    parameter int                   STAGE_NUM  = 3,
    parameter int                   ADDR_WIDTH = 2,
    parameter logic [STAGE_NUM-1:0] PIPED_MASK = 3'b101
) (
    input  logic          clk,
    input  logic          rst,
    bf_pdep_pipe_if.slave bus
);
    localparam int N     = DATA_WIDTH / LANES;
    localparam int HALF  = N / 2;
    localparam int CW    = STAGE_NUM * HALF;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [7:0] STAGE_LIM = 8'(STAGE_NUM);

    // Element q of lane p sits at bit LANES*q+p, so swapping elements across all
    // lanes is a swap of bit groups and no lane shuffle is needed at either end.
    function automatic logic [DATA_WIDTH-1:0] butterfly(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [HALF-1:0]       ctl,
                                                        input int                    s);
        logic [DATA_WIDTH-1:0] r;
        int lo;
        int hi;
        r = d;
        for (int k = 0; k < HALF; k++) begin
            lo = ((k >> s) << (s + 1)) + (k & ((1 << s) - 1));
            hi = lo + (1 << s);
            if (ctl[k]) begin
                for (int p = 0; p < LANES; p++) begin
                    r[LANES*lo+p] = d[LANES*hi+p];
                    r[LANES*hi+p] = d[LANES*lo+p];
                end
            end
        end
        return r;
    endfunction

    logic [CW-1:0]         r_cfg [DEPTH];
    logic                  r_cfg_err;
    logic                  r_in_vld;
    logic [DATA_WIDTH-1:0] r_in_dat;
    logic [CW-1:0]         r_in_cfg;
    logic                  r_stg_vld [STAGE_NUM];
    logic [DATA_WIDTH-1:0] r_stg_dat [STAGE_NUM];
    logic [CW-1:0]         r_stg_cfg [STAGE_NUM];
    logic                  w_stg_vld [STAGE_NUM];
    logic [DATA_WIDTH-1:0] w_stg_dat [STAGE_NUM];
    logic [CW-1:0]         w_stg_cfg [STAGE_NUM];
    logic                  w_cur_vld;
    logic [DATA_WIDTH-1:0] w_cur_dat;
    logic [CW-1:0]         w_cur_cfg;
    logic                  w_adv;

    assign w_adv       = !w_cur_vld || bus.m_ready;
    assign bus.s_ready = w_adv && !rst;
    assign bus.m_valid = w_cur_vld && !rst;
    assign bus.m_data  = w_cur_dat;
    assign bus.cfg_err = r_cfg_err;

    // Out-of-range stage writes are dropped; the error pulse follows one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) r_cfg[a] <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= bus.cfg_we && (bus.cfg_stage >= STAGE_LIM);
            if (bus.cfg_we) begin
                for (int s = 0; s < STAGE_NUM; s++) begin
                    if (bus.cfg_stage == 8'(s)) r_cfg[bus.cfg_addr][s*HALF +: HALF] <= bus.cfg_wdata;
                end
            end
        end
    end

    // Walk the stages in order; a registered stage breaks the chain at its flop.
    always_comb begin
        w_cur_vld = r_in_vld;
        w_cur_dat = r_in_dat;
        w_cur_cfg = r_in_cfg;
        for (int s = 0; s < STAGE_NUM; s++) begin
            w_stg_vld[s] = w_cur_vld;
            w_stg_dat[s] = butterfly(w_cur_dat, w_cur_cfg[s*HALF +: HALF], s);
            w_stg_cfg[s] = w_cur_cfg;
            if (PIPED_MASK[s]) begin
                w_cur_vld = r_stg_vld[s];
                w_cur_dat = r_stg_dat[s];
                w_cur_cfg = r_stg_cfg[s];
            end else begin
                w_cur_vld = w_stg_vld[s];
                w_cur_dat = w_stg_dat[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_vld <= 1'b0;
            for (int s = 0; s < STAGE_NUM; s++) begin
                if (PIPED_MASK[s]) r_stg_vld[s] <= 1'b0;
            end
        end else if (w_adv) begin
            r_in_vld <= bus.s_valid;
            for (int s = 0; s < STAGE_NUM; s++) begin
                if (PIPED_MASK[s]) r_stg_vld[s] <= w_stg_vld[s];
            end
        end
    end

    // The config word is sampled with the beat, so later writes cannot reach it.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_in_dat <= bus.s_data;
            r_in_cfg <= r_cfg[bus.s_addr];
            for (int s = 0; s < STAGE_NUM; s++) begin
                if (PIPED_MASK[s]) begin
                    r_stg_dat[s] <= w_stg_dat[s];
                    if (s < STAGE_NUM - 1) r_stg_cfg[s] <= w_stg_cfg[s];
                end
            end
        end
    end
endmodule

// File: tb/tb_bf_pdep_pipe.sv
// Self-checking bench for bf_pdep_pipe: directed vectors, same-cycle config
// write, error pulse, output stall with random traffic and mid-stream reset.
module tb_bf_pdep_pipe;
    localparam int DW = 16;
    localparam int AW = 2;
    localparam int H  = 4;
    localparam int SN = 3;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [DW-1:0]   exp_q[$];
    logic [DW-1:0]   mon_exp;
    logic [SN*H-1:0] shadow [4];

    bf_pdep_pipe_if #(.DATA_WIDTH(DW), .LANES(2), .ADDR_WIDTH(AW)) bus ();

    bf_pdep_pipe #(
        .DATA_WIDTH(DW), .LANES(2), .STAGE_NUM(SN), .ADDR_WIDTH(AW), .PIPED_MASK(3'b101)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation ran past time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: stage s swaps elements q and q+2**s for every q with bit s clear.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [SN*H-1:0] c);
        logic [DW-1:0] r;
        logic t;
        int span;
        int k;
        r = d;
        for (int s = 0; s < SN; s++) begin
            span = 1 << s;
            for (int q = 0; q < 8; q++) begin
                if ((q & span) == 0) begin
                    k = (q >> (s + 1)) * span + (q % span);
                    if (c[s*H+k]) begin
                        for (int p = 0; p < 2; p++) begin
                            t = r[2*q+p];
                            r[2*q+p] = r[2*(q+span)+p];
                            r[2*(q+span)+p] = t;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_beat: got %0h want no beat", bus.m_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("m_data", bus.m_data, mon_exp);
            end
        end
    end

    // driver tasks: called just after a rising edge, return just after one
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] e);
        int n;
        logic hs;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_addr  = a;
        bus.s_data  = d;
        do begin
            @(negedge clk);
            hs = bus.s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 200);
        if (hs) exp_q.push_back(e);
        else begin
            total++;
            bad++;
            $display("FAIL send_timeout: got s_ready %0d want 1", hs);
        end
    endtask

    task automatic idle();
        bus.s_valid = 1'b0;
    endtask

    task automatic cfg_wr(input logic [AW-1:0] a, input logic [7:0] st, input logic [H-1:0] w);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_stage = st;
        bus.cfg_wdata = w;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        if (st < 8'(SN)) shadow[a][st*H +: H] = w;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];
    logic [DW-1:0] held;
    int n;
    int c0;

    initial begin
        vecs[0] = '{addr: 2'd1, data: 16'h0001, exp: 16'h0004};
        vecs[1] = '{addr: 2'd1, data: 16'h0002, exp: 16'h0008};
        vecs[2] = '{addr: 2'd3, data: 16'h0001, exp: 16'h0100};
        vecs[3] = '{addr: 2'd3, data: 16'h0004, exp: 16'h0040};
        vecs[4] = '{addr: 2'd3, data: 16'h0008, exp: 16'h0080};
        vecs[5] = '{addr: 2'd0, data: 16'hA5C3, exp: 16'hA5C3};
        vecs[6] = '{addr: 2'd1, data: 16'h8000, exp: 16'h2000};
        vecs[7] = '{addr: 2'd1, data: 16'h0033, exp: 16'h00CC};
        for (int a = 0; a < 4; a++) shadow[a] = '0;

        bus.s_valid = 1'b0; bus.s_addr = '0; bus.s_data = '0; bus.m_ready = 1'b1;
        // a write issued during reset must be dropped
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_stage = 8'd0; bus.cfg_wdata = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_cfg_err", bus.cfg_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.cfg_we = 1'b0;
        @(negedge clk);
        chk("s_ready_after_rst", bus.s_ready, 1);
        @(posedge clk);
        #1;

        // identity config and first-beat latency
        send(2'd0, 16'hA5C3, 16'hA5C3);
        idle();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.m_valid && n < 10);
        chk("latency", n, 3);
        @(posedge clk);
        #1;

        // table vectors, back to back
        cfg_wr(2'd1, 8'd0, 4'b1111);
        cfg_wr(2'd3, 8'd1, 4'b0010);
        cfg_wr(2'd3, 8'd2, 4'b0001);
        c0 = cyc;
        for (int i = 0; i < 8; i++) send(vecs[i].addr, vecs[i].data, vecs[i].exp);
        chk("throughput_cycles", cyc - c0, 8);
        idle();
        drain();

        // write and acceptance on the same edge: beat sees the old word
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd2; bus.cfg_stage = 8'd0; bus.cfg_wdata = 4'b1111;
        send(2'd2, 16'h0001, 16'h0001);
        bus.cfg_we = 1'b0;
        shadow[2][3:0] = 4'b1111;
        send(2'd2, 16'h0001, 16'h0004);
        idle();
        drain();

        // out-of-range stage index
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_stage = 8'd3; bus.cfg_wdata = 4'b1111;
        @(negedge clk);
        chk("cfg_err_before", bus.cfg_err, 0);
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        @(negedge clk);
        chk("cfg_err_pulse", bus.cfg_err, 1);
        @(negedge clk);
        chk("cfg_err_clear", bus.cfg_err, 0);
        @(posedge clk);
        #1;
        send(2'd0, 16'h1234, 16'h1234);
        idle();
        drain();

        // random configs, random traffic, 5-cycle output stall
        for (int a = 0; a < 4; a++)
            for (int s = 0; s < SN; s++) cfg_wr(2'(a), 8'(s), 4'($urandom_range(0, 15)));
        fork
            begin
                logic [DW-1:0] d;
                logic [AW-1:0] a;
                for (int i = 0; i < 20; i++) begin
                    d = 16'($urandom_range(0, 65535));
                    a = 2'($urandom_range(0, 3));
                    send(a, d, model(d, shadow[a]));
                end
                idle();
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                bus.m_ready = 1'b0;
                @(negedge clk);
                held = bus.m_data;
                chk("stall_m_valid", bus.m_valid, 1);
                chk("stall_s_ready", bus.s_ready, 0);
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_m_data", bus.m_data, held);
                    chk("stall_m_valid", bus.m_valid, 1);
                    chk("stall_s_ready", bus.s_ready, 0);
                end
                @(posedge clk);
                #1;
                bus.m_ready = 1'b1;
            end
        join
        drain();

        // reset with two beats in flight
        send(2'd0, 16'h1111, model(16'h1111, shadow[0]));
        send(2'd0, 16'h2222, model(16'h2222, shadow[0]));
        rst = 1'b1;
        idle();
        exp_q.delete();
        @(negedge clk);
        chk("midrst_m_valid", bus.m_valid, 0);
        chk("midrst_s_ready", bus.s_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int a = 0; a < 4; a++) shadow[a] = '0;
        @(negedge clk);
        chk("s_ready_after_midrst", bus.s_ready, 1);
        repeat (6) begin
            @(negedge clk);
            chk("no_stale_beat", bus.m_valid, 0);
        end
        @(posedge clk);
        #1;
        send(2'd1, 16'h0001, 16'h0001);
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
